register_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `register` instance between `N_REQ` independent requesters. Each requester asks for a load or an increment through a req/ack handshake. The arbiter serialises the requests and drives the register's `ctrl` and `data_input` for exactly one cycle per granted operation. It returns the post-operation register value with the ack. It sits between requester logic (button front-ends, control FSMs) and the register, replacing hard-wired priority muxing of `ctrl`.

---
 rtl/register_access_arbiter.sv | 159 +++++++++++++++
 tb/tb_register_access_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_access_arbiter.sv
// register_access_arbiter
//   Round-robin arbiter/sequencer that lets N_REQ requesters share one register.
//   Each granted operation drives reg_ctrl with LD or INC for exactly one cycle
//   (ISSUE). The next cycle (COMPLETE) acks the requester and returns the
//   post-operation register value.
// Ports:
//   clk, async_reset         clock; synchronous active-high reset
//   req/req_load/req_data    per-requester request, op select (1=load), load data
//   ack, grant               one-hot completion pulse, one-hot current owner
//   rd_data                  register value after the acked op, held to next ack
//   busy                     high in ISSUE and COMPLETE
//   reg_ctrl/reg_data_input  command and data to the shared register
//   reg_data_output          current value of the shared register
module register_access_arbiter #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned REG_CTRL_WIDTH = 2,
   parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = REG_CTRL_WIDTH'(0),
   parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = REG_CTRL_WIDTH'(1),
   parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = REG_CTRL_WIDTH'(2)
) (
   input  logic                      clk,
   input  logic                      async_reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_load,
   input  logic [N_REQ*WIDTH-1:0]    req_data,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          grant,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      busy,
   output logic [REG_CTRL_WIDTH-1:0] reg_ctrl,
   output logic [WIDTH-1:0]          reg_data_input,
   input  logic [WIDTH-1:0]          reg_data_output
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_COMPLETE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          last_q, last_d;
   logic [N_REQ-1:0]          grant_q, grant_d;
   logic [N_REQ-1:0]          ack_q, ack_d;
   logic                      busy_q, busy_d;
   logic [REG_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]          din_q, din_d;
   logic [WIDTH-1:0]          rd_q, rd_d;

   logic [N_REQ-1:0]          cand;
   logic [IDX_W-1:0]          cand_idx;
   logic [IDX_W-1:0]          win_idx;
   logic                      win_found;

   // The owner being acked may still hold req in the COMPLETE cycle; skip it.
   assign cand = req & ~((state_q == S_COMPLETE) ? grant_q : '0);

   // Round-robin search starting just after the last granted index.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand_idx = IDX_W'((32'(last_q) + k) % N_REQ);
         if (!win_found && cand[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      ack_d   = '0;
      busy_d  = busy_q;
      ctrl_d  = REG_CTRL_NOP;
      din_d   = din_q;
      rd_d    = rd_q;

      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (win_found) begin
               state_d = S_ISSUE;
               grant_d = N_REQ'(1) << win_idx;
               last_d  = win_idx;
               busy_d  = 1'b1;
               ctrl_d  = req_load[win_idx] ? REG_CTRL_LD : REG_CTRL_INC;
               din_d   = req_data[32'(win_idx)*WIDTH +: WIDTH];
            end
         end
         S_ISSUE: begin
            state_d = S_COMPLETE;
            ack_d   = grant_q;
            busy_d  = 1'b1;
         end
         S_COMPLETE: begin
            rd_d = reg_data_output;
            if (win_found) begin
               state_d = S_ISSUE;
               grant_d = N_REQ'(1) << win_idx;
               last_d  = win_idx;
               busy_d  = 1'b1;
               ctrl_d  = req_load[win_idx] ? REG_CTRL_LD : REG_CTRL_INC;
               din_d   = req_data[32'(win_idx)*WIDTH +: WIDTH];
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (async_reset) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(N_REQ - 1);
         grant_q <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         ctrl_q  <= REG_CTRL_NOP;
         din_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         ctrl_q  <= ctrl_d;
         din_q   <= din_d;
         rd_q    <= rd_d;
      end
   end

   // The register updates on the edge ending ISSUE, so its output already holds
   // the result during COMPLETE; show it directly then, the held copy otherwise.
   assign rd_data        = (state_q == S_COMPLETE) ? reg_data_output : rd_q;
   assign ack            = ack_q;
   assign grant          = grant_q;
   assign busy           = busy_q;
   assign reg_ctrl       = ctrl_q;
   assign reg_data_input = din_q;

endmodule

// File: tb/tb_register_access_arbiter.sv
// Directed plus randomized bench for register_access_arbiter, with a simple
// model of the shared register and a transaction-level round-robin reference.
module tb_register_access_arbiter;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned CW = 2;
   localparam logic [CW-1:0] C_NOP = 2'd0;
   localparam logic [CW-1:0] C_LD  = 2'd1;
   localparam logic [CW-1:0] C_INC = 2'd2;

   logic            clk = 1'b0;
   logic            async_reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    req_load = '0;
   logic [N*W-1:0]  req_data = '0;
   logic [N-1:0]    ack;
   logic [N-1:0]    grant;
   logic [W-1:0]    rd_data;
   logic            busy;
   logic [CW-1:0]   reg_ctrl;
   logic [W-1:0]    reg_data_input;
   logic [W-1:0]    reg_data_output;

   logic [W-1:0]    reg_q = '0;
   int              cyc = 0;
   int              ld_cnt = 0;
   int              inc_cnt = 0;

   int              checks = 0;
   int              errors = 0;
   int              model_last = int'(N) - 1;
   logic [W-1:0]    model_reg = '0;

   register_access_arbiter #(
      .WIDTH(W), .N_REQ(N), .REG_CTRL_WIDTH(CW),
      .REG_CTRL_NOP(C_NOP), .REG_CTRL_LD(C_LD), .REG_CTRL_INC(C_INC)
   ) dut (
      .clk(clk), .async_reset(async_reset),
      .req(req), .req_load(req_load), .req_data(req_data),
      .ack(ack), .grant(grant), .rd_data(rd_data), .busy(busy),
      .reg_ctrl(reg_ctrl), .reg_data_input(reg_data_input),
      .reg_data_output(reg_data_output)
   );

   always #5 clk = ~clk;

   // Shared register model: load, increment (wrapping), or hold.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (async_reset) reg_q <= '0;
      else if (reg_ctrl == C_LD) reg_q <= reg_data_input;
      else if (reg_ctrl == C_INC) reg_q <= reg_q + 1'b1;
      if (reg_ctrl == C_LD) ld_cnt <= ld_cnt + 1;
      if (reg_ctrl == C_INC) inc_cnt <= inc_cnt + 1;
   end
   assign reg_data_output = reg_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin reference: first pending index after 'last', modulo N.
   function automatic int rr_pick(input logic [N-1:0] pend, input int last);
      for (int k = 1; k <= int'(N); k++) begin
         if (pend[(last + k) % int'(N)]) return (last + k) % int'(N);
      end
      return 0;
   endfunction

   task automatic wait_ack(output logic [N-1:0] a);
      a = '0;
      for (int i = 0; i < 4 * int'(N) + 4; i++) begin
         @(negedge clk);
         if (ack != '0) begin
            a = ack;
            break;
         end
      end
      checks++;
      assert (a != '0) else begin
         errors++;
         $error("FAIL ack_timeout: observed 0x0 expected nonzero ack");
      end
   endtask

   // Raise a set of requests together, then serve them one by one as the model predicts.
   task automatic run_batch(input logic [N-1:0] mask, input logic [N-1:0] loads,
                            input logic [N*W-1:0] datas);
      logic [N-1:0] pend;
      logic [N-1:0] a;
      logic [W-1:0] expv;
      int           w;
      int           t0;
      req_load = loads;
      req_data = datas;
      req      = mask;
      pend     = mask;
      t0       = cyc;
      while (pend != '0) begin
         w    = rr_pick(pend, model_last);
         expv = loads[w] ? datas[w*W +: W] : model_reg + 1'b1;
         wait_ack(a);
         check("ack_owner", 32'(a), 32'(N'(1) << w));
         check("ack_spacing", 32'(cyc - t0), 32'd2);
         check("rd_data", 32'(rd_data), 32'(expv));
         t0 = cyc;
         req[w]     = 1'b0;
         pend[w]    = 1'b0;
         model_reg  = expv;
         model_last = w;
      end
      @(negedge clk);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      logic [N-1:0] a;
      int           w;
      int           base;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);
      check("rst_ctrl", 32'(reg_ctrl), 32'(C_NOP));
      check("rst_din", 32'(reg_data_input), 32'd0);
      async_reset = 1'b0;
      @(negedge clk);

      // LD 0x5A from requester 2, cycle-accurate
      base     = ld_cnt;
      req_load = 4'b0100;
      req_data = 32'h005A_0000;
      req      = 4'b0100;
      @(negedge clk);
      check("t1_ctrl", 32'(reg_ctrl), 32'(C_LD));
      check("t1_din", 32'(reg_data_input), 32'h5A);
      check("t1_grant", 32'(grant), 32'h4);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_noack", 32'(ack), 32'd0);
      @(negedge clk);
      check("t2_ack", 32'(ack), 32'h4);
      check("t2_rd", 32'(rd_data), 32'h5A);
      check("t2_ctrl", 32'(reg_ctrl), 32'(C_NOP));
      req = '0;
      @(negedge clk);
      check("t3_ack", 32'(ack), 32'd0);
      check("t3_rd_hold", 32'(rd_data), 32'h5A);
      check("t3_grant", 32'(grant), 32'd0);
      check("ld_count", 32'(ld_cnt - base), 32'd1);
      model_last = 2;
      model_reg  = 8'h5A;
      @(negedge clk);

      // Wrap: load 0xFF, then INC from requester 1
      run_batch(4'b0001, 4'b0001, 32'h0000_00FF);
      base = inc_cnt;
      run_batch(4'b0010, 4'b0000, '0);
      check("wrap_rd", 32'(rd_data), 32'h00);
      check("wrap_inc_count", 32'(inc_cnt - base), 32'd1);

      // Register to 0 via requester 3, then all four INC together
      run_batch(4'b1000, 4'b1000, '0);
      run_batch(4'b1111, 4'b0000, '0);
      check("all4_final", 32'(rd_data), 32'h04);

      // Requester 3 held high, requester 1 re-requests after each ack
      req_load = '0;
      req      = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         w = rr_pick(4'b1010, model_last);
         wait_ack(a);
         check("alt_owner", 32'(a), 32'(N'(1) << w));
         check("alt_rd", 32'(rd_data), 32'(model_reg + 1'b1));
         model_reg  = model_reg + 1'b1;
         model_last = w;
         if (w == 1 && i < 5) begin
            req[1] = 1'b0;
            @(negedge clk);
            req[1] = 1'b1;
         end
      end
      req = '0;
      repeat (3) @(negedge clk);
      check("alt_idle", 32'(busy), 32'd0);

      // Reset during ISSUE of LD 0x33; request is reissued afterwards
      req_load = 4'b0001;
      req_data = 32'h0000_0033;
      req      = 4'b0001;
      @(negedge clk);
      check("rs_issue", 32'(reg_ctrl), 32'(C_LD));
      async_reset = 1'b1;
      @(negedge clk);
      check("rs_ctrl", 32'(reg_ctrl), 32'(C_NOP));
      check("rs_ack", 32'(ack), 32'd0);
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_rd", 32'(rd_data), 32'd0);
      async_reset = 1'b0;
      model_last  = int'(N) - 1;
      model_reg   = '0;
      wait_ack(a);
      check("rs_reissue_ack", 32'(a), 32'h1);
      check("rs_reissue_rd", 32'(rd_data), 32'h33);
      req        = '0;
      model_last = 0;
      model_reg  = 8'h33;
      repeat (2) @(negedge clk);

      // Load data changed after the latch has no effect
      req_load = 4'b0100;
      req_data = 32'h00A5_0000;
      req      = 4'b0100;
      @(negedge clk);
      req_data = 32'h0011_0000;
      req_load = 4'b0000;
      wait_ack(a);
      check("latch_ack", 32'(a), 32'h4);
      check("latch_rd", 32'(rd_data), 32'hA5);
      req        = '0;
      model_last = 2;
      model_reg  = 8'hA5;
      repeat (2) @(negedge clk);

      // Randomized batches against the reference model
      for (int r = 0; r < 25; r++) begin
         run_batch(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), (N*W)'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
